// File: rtl/dpb_udp_reader_if.sv
// Bus bundle between the DPB read side, the slot writer handshake and the udp128 packetiser.
// master = dpb_udp_reader, slave = its environment (DPB port B, writer, packetiser).
interface dpb_udp_reader_if;
  logic         i_slot_valid;
  logic [3:0]   i_slot_rank;
  logic [11:0]  i_slot_bytes;
  logic         i_slot_last;
  logic         o_slot_free;
  logic [3:0]   o_slot_free_rank;
  logic [10:0]  o_dpb_b_addr;
  logic         o_dpb_b_clk;
  logic         o_dpb_b_cea;
  logic         o_dpb_b_ocea;
  logic         o_dpb_b_wr_en;
  logic         o_dpb_b_rst_n;
  logic [127:0] o_dpb_b_wr_data;
  logic [127:0] i_dpb_b_rd_data;
  logic         o_udp_en;
  logic [15:0]  o_udp_jpeg_len;
  logic         o_udp_last_flag;
  logic [14:0]  o_udp_frame_rank;
  logic [15:0]  o_udp_ipv4_sign;
  logic [127:0] o_udp_wrdata;
  logic         i_udp_data_req;
  logic         i_udp_busy;
  logic         i_udp_frame_down;
  logic         o_error;

  modport master (
    input  i_slot_valid, i_slot_rank, i_slot_bytes, i_slot_last, i_dpb_b_rd_data,
           i_udp_data_req, i_udp_busy, i_udp_frame_down,
    output o_slot_free, o_slot_free_rank, o_dpb_b_addr, o_dpb_b_clk, o_dpb_b_cea,
           o_dpb_b_ocea, o_dpb_b_wr_en, o_dpb_b_rst_n, o_dpb_b_wr_data, o_udp_en,
           o_udp_jpeg_len, o_udp_last_flag, o_udp_frame_rank, o_udp_ipv4_sign,
           o_udp_wrdata, o_error
  );

  modport slave (
    output i_slot_valid, i_slot_rank, i_slot_bytes, i_slot_last, i_dpb_b_rd_data,
           i_udp_data_req, i_udp_busy, i_udp_frame_down,
    input  o_slot_free, o_slot_free_rank, o_dpb_b_addr, o_dpb_b_clk, o_dpb_b_cea,
           o_dpb_b_ocea, o_dpb_b_wr_en, o_dpb_b_rst_n, o_dpb_b_wr_data, o_udp_en,
           o_udp_jpeg_len, o_udp_last_flag, o_udp_frame_rank, o_udp_ipv4_sign,
           o_udp_wrdata, o_error
  );
endinterface

// File: rtl/dpb_udp_reader.sv
// Drains completed 2 KB DPB slots through port B as 128-bit words to the UDP packetiser,
// supplies per-packet header fields and hands each slot back to the writer after transmission.
module dpb_udp_reader #(
  parameter int          SLOT_NUM       = 16,
  parameter logic [15:0] IPV4_SIGN_INI  = 16'h0,
  parameter logic [14:0] FRAME_RANK_INI = 15'h0
) (
  input  logic             i_cam_pclk,
  input  logic             rst_n,
  dpb_udp_reader_if.master bus
);

  localparam int PW = $clog2(SLOT_NUM);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_ANNOUNCE = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  typedef struct packed {
    logic [3:0]  rank;
    logic [11:0] bytes;
    logic        last;
  } slot_t;

  slot_t        fifo_q [SLOT_NUM];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  logic [2:0]   state_q, state_d;
  logic [3:0]   rank_q, rank_d;
  logic [15:0]  len_q, len_d;
  logic         last_q, last_d;
  logic [7:0]   word_idx_q, word_idx_d;
  logic [15:0]  sign_q, sign_d;
  logic [14:0]  frame_q, frame_d;
  logic         err_q, err_d;
  logic         rd_vld1_q, rd_vld2_q;
  logic [127:0] wrdata_q, wrdata_d;

  logic  fifo_empty, fifo_full, pop, push_ok, overflow;
  logic  more_words, in_send, req_ok, req_bad, fd_bad;
  slot_t head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(SLOT_NUM));
  assign pop        = (state_q == S_LOAD);
  // A full FIFO still accepts a push in the cycle its head is popped.
  assign push_ok    = bus.i_slot_valid && (!fifo_full || pop);
  assign overflow   = bus.i_slot_valid && fifo_full && !pop;
  assign head       = fifo_q[rd_ptr_q];

  // word_idx < ceil(bytes/16) is the same test as word_idx*16 < bytes.
  assign more_words = ({4'b0, word_idx_q, 4'b0} < len_q);
  assign in_send    = (state_q == S_SEND) && !bus.i_udp_frame_down;
  assign req_ok     = in_send && bus.i_udp_data_req && more_words;
  assign req_bad    = in_send && bus.i_udp_data_req && !more_words;
  assign fd_bad     = bus.i_udp_frame_down && (state_q != S_SEND);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rank_d     = rank_q;
    len_d      = len_q;
    last_d     = last_q;
    word_idx_d = word_idx_q;
    sign_d     = sign_q;
    frame_d    = frame_q;
    case (state_q)
      S_IDLE:     if (!fifo_empty) state_d = S_LOAD;
      S_LOAD: begin
        rank_d     = head.rank;
        len_d      = {4'b0, head.bytes};
        last_d     = head.last;
        word_idx_d = '0;
        state_d    = S_ANNOUNCE;
      end
      S_ANNOUNCE: if (bus.i_udp_busy) state_d = S_SEND;
      S_SEND: begin
        if (bus.i_udp_frame_down) state_d = S_RELEASE;
        else if (req_ok)          word_idx_d = word_idx_q + 8'd1;
      end
      S_RELEASE: begin
        sign_d  = sign_q + 16'd1;
        if (last_q) frame_d = frame_q + 15'd1;
        state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
    err_d    = err_q | overflow | req_bad | fd_bad;
    wrdata_d = rd_vld2_q ? bus.i_dpb_b_rd_data : wrdata_q;
  end

  always_ff @(posedge i_cam_pclk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= {bus.i_slot_rank, bus.i_slot_bytes, bus.i_slot_last};
  end

  always_ff @(posedge i_cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      rank_q     <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      word_idx_q <= '0;
      sign_q     <= IPV4_SIGN_INI;
      frame_q    <= FRAME_RANK_INI;
      err_q      <= 1'b0;
      rd_vld1_q  <= 1'b0;
      rd_vld2_q  <= 1'b0;
      wrdata_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      rank_q     <= rank_d;
      len_q      <= len_d;
      last_q     <= last_d;
      word_idx_q <= word_idx_d;
      sign_q     <= sign_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
      rd_vld1_q  <= req_ok;
      rd_vld2_q  <= rd_vld1_q;
      wrdata_q   <= wrdata_d;
    end
  end

  // Read data lands two cycles after the request; forward it in that cycle, hold it afterwards.
  assign bus.o_udp_wrdata     = wrdata_d;
  assign bus.o_dpb_b_addr     = {rank_q, word_idx_q[6:0]};
  assign bus.o_dpb_b_cea      = req_ok;
  assign bus.o_dpb_b_ocea     = rd_vld1_q;
  assign bus.o_dpb_b_clk      = i_cam_pclk;
  assign bus.o_dpb_b_wr_en    = 1'b0;
  assign bus.o_dpb_b_rst_n    = rst_n;
  assign bus.o_dpb_b_wr_data  = '0;
  assign bus.o_udp_en         = (state_q == S_ANNOUNCE);
  assign bus.o_udp_jpeg_len   = len_q;
  assign bus.o_udp_last_flag  = last_q;
  assign bus.o_udp_frame_rank = frame_q;
  assign bus.o_udp_ipv4_sign  = sign_q;
  assign bus.o_slot_free      = (state_q == S_RELEASE);
  assign bus.o_slot_free_rank = rank_q;
  assign bus.o_error          = err_q;

endmodule
